// File: rtl/reg_wr_sequencer_pkg.sv
// Shared constants for the register write sequencer.
// Load-select encodings and the arbiter's reset pointer.
package reg_wr_sequencer_pkg;

  localparam logic [1:0] LD_HOLD = 2'b00;
  localparam logic [1:0] LD_SRC1 = 2'b01;
  localparam logic [1:0] LD_SRC2 = 2'b10;
  localparam logic [1:0] LD_SRC3 = 2'b11;

  localparam logic [1:0] LAST_GRANT_RST = LD_SRC3;

endpackage

// File: rtl/wr_slot.sv
// One-entry write slot: parks a single request until granted.
// A grant and a new transfer at the same edge keep the slot full.
module wr_slot
  import reg_wr_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [N-1:0] wr_data,
  input  logic         grant,
  output logic         ready,
  output logic         full,
  output logic [N-1:0] slot_data
);

  logic         full_q;
  logic [N-1:0] buf_q;

  assign ready     = !rst && (!full_q || grant);
  assign full      = full_q;
  assign slot_data = buf_q;

  // Capture on handshake; release the slot when it is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else if (valid && ready) begin
      full_q <= 1'b1;
      buf_q  <= wr_data;
    end else if (grant) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_wr_sequencer.sv
// Three-source write driver for a load-select register.
// Round-robin over one-entry slots, one load per cycle.
module reg_wr_sequencer
  import reg_wr_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src1_valid_i,
  input  logic [N-1:0] src1_data_i,
  output logic         src1_ready_o,
  input  logic         src2_valid_i,
  input  logic [N-1:0] src2_data_i,
  output logic         src2_ready_o,
  input  logic         src3_valid_i,
  input  logic [N-1:0] src3_data_i,
  output logic         src3_ready_o,
  input  logic         stall_i,
  output logic [1:0]   ld_o,
  output logic [N-1:0] data1_o,
  output logic [N-1:0] data2_o,
  output logic [N-1:0] data3_o,
  output logic         busy_o
);

  logic [2:0]   valid;
  logic [2:0]   full;
  logic [2:0]   grant;
  logic [2:0]   ready;
  logic [N-1:0] wr_data [3];
  logic [N-1:0] slot_data [3];
  logic [1:0]   last_grant;
  logic [1:0]   ld;

  assign valid = {src3_valid_i, src2_valid_i, src1_valid_i};

  assign wr_data[0] = src1_data_i;
  assign wr_data[1] = src2_data_i;
  assign wr_data[2] = src3_data_i;

  for (genvar k = 0; k < 3; k++) begin : g_slot
    wr_slot #(
      .N(N)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid[k]),
      .wr_data  (wr_data[k]),
      .grant    (grant[k]),
      .ready    (ready[k]),
      .full     (full[k]),
      .slot_data(slot_data[k])
    );
  end

  // Pick the first full slot after the last one served.
  always_comb begin
    ld = LD_HOLD;
    if (!stall_i && |full) begin
      unique case (last_grant)
        LD_SRC1:
          ld = full[1] ? LD_SRC2 :
               full[2] ? LD_SRC3 : LD_SRC1;
        LD_SRC2:
          ld = full[2] ? LD_SRC3 :
               full[0] ? LD_SRC1 : LD_SRC2;
        default:
          ld = full[0] ? LD_SRC1 :
               full[1] ? LD_SRC2 : LD_SRC3;
      endcase
    end
  end

  // Decode the load select into per-slot grants.
  always_comb begin
    grant = 3'b000;
    unique case (1'b1)
      (ld == LD_SRC1): grant[0] = 1'b1;
      (ld == LD_SRC2): grant[1] = 1'b1;
      (ld == LD_SRC3): grant[2] = 1'b1;
      default:         grant    = 3'b000;
    endcase
  end

  // Remember who was served; frozen when nothing loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= LAST_GRANT_RST;
    end else if (ld != LD_HOLD) begin
      last_grant <= ld;
    end
  end

  assign ld_o         = ld;
  assign src1_ready_o = ready[0];
  assign src2_ready_o = ready[1];
  assign src3_ready_o = ready[2];
  assign data1_o      = slot_data[0];
  assign data2_o      = slot_data[1];
  assign data3_o      = slot_data[2];
  assign busy_o       = |full;

endmodule

// File: tb/tb_reg_wr_sequencer.sv
// Self-checking bench for reg_wr_sequencer.
// Directed scenarios plus randomized traffic against a slot model.
module tb_reg_wr_sequencer;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         src1_valid_i = 1'b0;
  logic [N-1:0] src1_data_i = '0;
  logic         src1_ready_o;
  logic         src2_valid_i = 1'b0;
  logic [N-1:0] src2_data_i = '0;
  logic         src2_ready_o;
  logic         src3_valid_i = 1'b0;
  logic [N-1:0] src3_data_i = '0;
  logic         src3_ready_o;
  logic         stall_i = 1'b0;
  logic [1:0]   ld_o;
  logic [N-1:0] data1_o;
  logic [N-1:0] data2_o;
  logic [N-1:0] data3_o;
  logic         busy_o;

  always #5 clk = ~clk;

  reg_wr_sequencer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .src1_valid_i(src1_valid_i),
    .src1_data_i (src1_data_i),
    .src1_ready_o(src1_ready_o),
    .src2_valid_i(src2_valid_i),
    .src2_data_i (src2_data_i),
    .src2_ready_o(src2_ready_o),
    .src3_valid_i(src3_valid_i),
    .src3_data_i (src3_data_i),
    .src3_ready_o(src3_ready_o),
    .stall_i     (stall_i),
    .ld_o        (ld_o),
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .data3_o     (data3_o),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_full [1:3];
  logic [31:0] m_buf  [1:3];
  int          m_last;

  logic [1:0]  o_ld, e_ld;
  logic [2:0]  o_rdy, e_rdy;
  logic        o_busy, e_busy;
  logic [31:0] o_d [1:3];
  logic [31:0] e_d [1:3];

  function automatic int model_grant(bit stall);
    if (stall) return 0;
    for (int i = 1; i <= 3; i++) begin
      int k;
      k = (m_last + i - 1) % 3 + 1;
      if (m_full[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= 3; k++) begin
      m_full[k] = 1'b0;
      m_buf[k]  = '0;
    end
    m_last = 3;
  endtask

  task automatic idle_inputs();
    src1_valid_i = 1'b0;
    src2_valid_i = 1'b0;
    src3_valid_i = 1'b0;
    stall_i      = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive, record model and DUT view, advance model.
  task automatic cycle(input logic [2:0] v,
                       input logic [31:0] d1,
                       input logic [31:0] d2,
                       input logic [31:0] d3,
                       input logic stall);
    int g;
    logic [31:0] d [1:3];
    d[1] = d1;
    d[2] = d2;
    d[3] = d3;
    @(negedge clk);
    src1_valid_i = v[0];
    src1_data_i  = d1;
    src2_valid_i = v[1];
    src2_data_i  = d2;
    src3_valid_i = v[2];
    src3_data_i  = d3;
    stall_i      = stall;
    #1;
    g      = model_grant(stall);
    e_ld   = 2'(g);
    e_busy = m_full[1] | m_full[2] | m_full[3];
    for (int k = 1; k <= 3; k++) begin
      e_rdy[k-1] = !m_full[k] || (g == k);
      e_d[k]     = m_buf[k];
    end
    o_ld   = ld_o;
    o_rdy  = {src3_ready_o, src2_ready_o, src1_ready_o};
    o_busy = busy_o;
    o_d[1] = data1_o;
    o_d[2] = data2_o;
    o_d[3] = data3_o;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      if (v[k-1] && e_rdy[k-1]) begin
        m_full[k] = 1'b1;
        m_buf[k]  = d[k];
      end else if (g == k) begin
        m_full[k] = 1'b0;
      end
    end
    if (g != 0) m_last = g;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ({ld_o, src3_ready_o, src2_ready_o, src1_ready_o, busy_o}
        !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ld=%b rdy=%b%b%b busy=%b want 0",
               ld_o, src3_ready_o, src2_ready_o, src1_ready_o, busy_o);
    end
    n_checks++;
    if ({data1_o, data2_o, data3_o} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want 0",
               data1_o, data2_o, data3_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    cycle(3'b010, 32'h0, 32'hA5A5_0002, 32'h0, 1'b0);
    n_checks++;
    if (o_rdy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 1", o_rdy[1]);
    end
    cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (o_ld !== 2'b10 || o_d[2] !== 32'hA5A5_0002) begin
      n_fail++;
      $display("FAIL single_load: got ld=%b d2=%h want 10 a5a50002",
               o_ld, o_d[2]);
    end
    cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (o_ld !== 2'b00 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got ld=%b busy=%b want 00 0",
               o_ld, o_busy);
    end
  endtask

  task automatic test_all_three();
    logic [1:0] want;
    apply_reset();
    cycle(3'b111, 32'h1, 32'h2, 32'h3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      want = (i < 3) ? 2'(i + 1) : 2'b00;
      cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (o_ld !== want) begin
        n_fail++;
        $display("FAIL all_three[%0d]: got ld=%b want %b", i, o_ld, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      cycle((i < 4) ? 3'b001 : 3'b000, 32'h10 + 32'(i),
            32'h0, 32'h0, 1'b0);
      if (i < 4) begin
        n_checks++;
        if (o_rdy[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready[%0d]: got %b want 1", i, o_rdy[0]);
        end
      end
      if (i >= 1) begin
        n_checks++;
        if (o_ld !== 2'b01 || o_d[1] !== 32'h10 + 32'(i - 1)) begin
          n_fail++;
          $display("FAIL b2b_load[%0d]: got ld=%b d1=%h want 01 %h",
                   i, o_ld, o_d[1], 32'h10 + 32'(i - 1));
        end
      end
    end
    cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (o_ld !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end: got ld=%b want 00", o_ld);
    end
  endtask

  task automatic test_stall();
    logic [1:0] order [3];
    order[0] = 2'b10;
    order[1] = 2'b11;
    order[2] = 2'b01;
    cycle(3'b111, 32'hC1, 32'hC2, 32'hC3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if (o_ld !== 2'b00 || o_rdy !== 3'b000 ||
          o_d[1] !== 32'hC1 || o_d[2] !== 32'hC2 ||
          o_d[3] !== 32'hC3) begin
        n_fail++;
        $display("FAIL stall[%0d]: got ld=%b rdy=%b d=%h/%h/%h",
                 i, o_ld, o_rdy, o_d[1], o_d[2], o_d[3]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (o_ld !== order[i]) begin
        n_fail++;
        $display("FAIL stall_resume[%0d]: got ld=%b want %b",
                 i, o_ld, order[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(3'b101, 32'hAAA1, 32'h0, 32'hAAA3, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (ld_o !== 2'b11 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got ld=%b busy=%b want 11 1", ld_o, busy_o);
    end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({ld_o, busy_o, src3_ready_o, src2_ready_o, src1_ready_o}
        !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_async: got ld=%b busy=%b rdy=%b%b%b want 0",
               ld_o, busy_o, src3_ready_o, src2_ready_o, src1_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(3'b100, 32'h0, 32'h0, 32'h33, 1'b0);
    n_checks++;
    if (o_busy !== 1'b0 || o_rdy !== 3'b111 || o_ld !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_empty: got busy=%b rdy=%b ld=%b want 0 111 00",
               o_busy, o_rdy, o_ld);
    end
    cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (o_ld !== 2'b11 || o_d[3] !== 32'h33) begin
      n_fail++;
      $display("FAIL mid_src3: got ld=%b d3=%h want 11 33", o_ld, o_d[3]);
    end
  endtask

  task automatic test_alternate();
    logic [31:0] d1, d3;
    logic [1:0]  want;
    cycle(3'b001, 32'h100, 32'h0, 32'h0, 1'b0);
    cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    d1 = 32'h200;
    d3 = 32'h300;
    for (int i = 0; i < 8; i++) begin
      cycle(3'b101, d1, 32'h0, d3, 1'b0);
      if (i >= 1) begin
        want = (i % 2 == 1) ? 2'b11 : 2'b01;
        n_checks++;
        if (o_ld !== want) begin
          n_fail++;
          $display("FAIL alternate[%0d]: got ld=%b want %b",
                   i, o_ld, want);
        end
      end
      if (e_rdy[0]) d1 = d1 + 1;
      if (e_rdy[2]) d3 = d3 + 1;
    end
    for (int i = 0; i < 2; i++)
      cycle(3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  pv;
    logic [31:0] pd [1:3];
    logic        st;
    apply_reset();
    pv = 3'b000;
    for (int k = 1; k <= 3; k++) pd[k] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 1; k <= 3; k++) begin
        if (!pv[k-1]) begin
          pv[k-1] = 1'($urandom_range(0, 1));
          pd[k]   = $urandom;
        end
      end
      st = ($urandom_range(0, 4) == 0);
      cycle(pv, pd[1], pd[2], pd[3], st);
      n_checks++;
      if ({o_ld, o_rdy, o_busy, o_d[1], o_d[2], o_d[3]} !==
          {e_ld, e_rdy, e_busy, e_d[1], e_d[2], e_d[3]}) begin
        n_fail++;
        $display("FAIL random[%0d]: got ld=%b rdy=%b busy=%b d=%h/%h/%h want ld=%b rdy=%b busy=%b d=%h/%h/%h",
                 c, o_ld, o_rdy, o_busy, o_d[1], o_d[2], o_d[3],
                 e_ld, e_rdy, e_busy, e_d[1], e_d[2], e_d[3]);
      end
      for (int k = 1; k <= 3; k++)
        if (pv[k-1] && e_rdy[k-1]) pv[k-1] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_three();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_alternate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
